// File: rtl/regular_topo_link_pipe_if.sv
// Router-to-router link channel bundle.
// One instance carries one direction of flits plus the credits that flow back
// against it.
//   flit_wr : flit valid
//   flit    : payload
//   hdr     : header flag
//   tail    : tail flag
//   vc      : one-hot virtual channel
//   credit  : per-VC credit returned toward the flit source
// Modports:
//   master : the side that produces flits and consumes credits
//   slave  : the side that consumes flits and produces credits
interface regular_topo_link_pipe_if #(
    parameter int FLIT_W = 32,
    parameter int V      = 4
);
    logic              flit_wr;
    logic [FLIT_W-1:0] flit;
    logic              hdr;
    logic              tail;
    logic [V-1:0]      vc;
    logic [V-1:0]      credit;

    modport master (
        output flit_wr,
        output flit,
        output hdr,
        output tail,
        output vc,
        input  credit
    );

    modport slave (
        input  flit_wr,
        input  flit,
        input  hdr,
        input  tail,
        input  vc,
        output credit
    );
endinterface

// File: rtl/regular_topo_link_pipe.sv
// Pipelined router-to-router link with a per-link drain controller.
// Flits travel from the upstream router to the downstream router through
// STAGES registers. Credits travel back through CRD_STAGES registers. When
// drain_req is raised, packets that are already open may finish. Credits for
// VCs with no open packet are held back, so upstream cannot start new packets.
// Once the link is empty, the controller reports IDLE. When drain_req drops,
// the held credits are paid back one per cycle per VC.
// Ports:
//   clk          : clock
//   reset        : asynchronous, active-low reset
//   up           : slave side facing the upstream router (flits in, credits out)
//   dn           : master side facing the downstream router (flits out, credits in)
//   drain_req    : level, 1 = drain and park the link, 0 = resume
//   link_state   : 0 ACTIVE, 1 DRAINING, 2 IDLE
//   inflight_cnt : number of flits held in the forward pipeline
//   proto_err    : sticky protocol error flag
module regular_topo_link_pipe #(
    parameter int FLIT_W     = 32,
    parameter int V          = 4,
    parameter int STAGES     = 2,
    parameter int CRD_STAGES = 2,
    parameter int B          = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    regular_topo_link_pipe_if.slave         up,
    regular_topo_link_pipe_if.master        dn,
    input  logic                            drain_req,
    output logic [1:0]                      link_state,
    output logic [3:0]                      inflight_cnt,
    output logic                            proto_err
);
    localparam int HW = $clog2(B + 1);

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_DRAINING = 2'd1,
        ST_IDLE     = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [V-1:0]   open_vc;
    logic [V-1:0]   crd_out;
    logic           crd_empty;
    logic [HW-1:0]  held     [V];
    logic [HW-1:0]  held_nxt [V];
    logic           held_ovf;
    logic           hdr_in_idle;
    logic           vc_bad;

    // Saturating increment for the withheld-credit counters.
    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] x);
        return (x == HW'(B)) ? x : x + HW'(1);
    endfunction

    function automatic logic is_onehot(input logic [V-1:0] x);
        return (x != '0) && ((x & (x - V'(1))) == '0);
    endfunction

    // Forward flit path.
    if (STAGES == 0) begin : g_fwd_comb
        assign dn.flit_wr   = up.flit_wr;
        assign dn.flit      = up.flit;
        assign dn.hdr       = up.hdr;
        assign dn.tail      = up.tail;
        assign dn.vc        = up.vc;
        assign inflight_cnt = 4'd0;
    end else begin : g_fwd_pipe
        logic [STAGES-1:0] vld_p;
        logic [FLIT_W-1:0] flit_p [STAGES];
        logic              hdr_p  [STAGES];
        logic              tail_p [STAGES];
        logic [V-1:0]      vc_p   [STAGES];

        // Stage valids (control, reset).
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= up.flit_wr;
                for (int i = 1; i < STAGES; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
            end
        end

        // Stage payloads: load only behind a valid, no reset.
        always_ff @(posedge clk) begin
            if (up.flit_wr) begin
                flit_p[0] <= up.flit;
                hdr_p[0]  <= up.hdr;
                tail_p[0] <= up.tail;
                vc_p[0]   <= up.vc;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (vld_p[i-1]) begin
                    flit_p[i] <= flit_p[i-1];
                    hdr_p[i]  <= hdr_p[i-1];
                    tail_p[i] <= tail_p[i-1];
                    vc_p[i]   <= vc_p[i-1];
                end
            end
        end

        // Output boundary: payload is masked when the last stage is empty.
        // This keeps dn_* at zero out of reset while the data registers
        // themselves stay unreset.
        assign dn.flit_wr = vld_p[STAGES-1];
        assign dn.flit    = vld_p[STAGES-1] ? flit_p[STAGES-1] : '0;
        assign dn.hdr     = vld_p[STAGES-1] & hdr_p[STAGES-1];
        assign dn.tail    = vld_p[STAGES-1] & tail_p[STAGES-1];
        assign dn.vc      = vld_p[STAGES-1] ? vc_p[STAGES-1] : '0;

        always_comb begin
            inflight_cnt = 4'd0;
            for (int i = 0; i < STAGES; i++) begin
                inflight_cnt = inflight_cnt + {3'b000, vld_p[i]};
            end
        end
    end

    // Credit return path.
    if (CRD_STAGES == 0) begin : g_crd_comb
        assign crd_out   = dn.credit;
        assign crd_empty = 1'b1;
    end else begin : g_crd_pipe
        logic [V-1:0] crd_p [CRD_STAGES];
        logic [V-1:0] crd_any;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < CRD_STAGES; i++) begin
                    crd_p[i] <= '0;
                end
            end else begin
                crd_p[0] <= dn.credit;
                for (int i = 1; i < CRD_STAGES; i++) begin
                    crd_p[i] <= crd_p[i-1];
                end
            end
        end

        always_comb begin
            crd_any = '0;
            for (int i = 0; i < CRD_STAGES; i++) begin
                crd_any = crd_any | crd_p[i];
            end
        end

        assign crd_out   = crd_p[CRD_STAGES-1];
        assign crd_empty = (crd_any == '0);
    end

    // A VC becomes open when a multi-flit header enters the link. It closes
    // when that packet's tail enters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            open_vc <= '0;
        end else if (up.flit_wr) begin
            for (int v = 0; v < V; v++) begin
                if (up.vc[v]) begin
                    if (up.hdr && !up.tail) begin
                        open_vc[v] <= 1'b1;
                    end else if (up.tail) begin
                        open_vc[v] <= 1'b0;
                    end
                end
            end
        end
    end

    assign hdr_in_idle = up.flit_wr && up.hdr && (state == ST_IDLE);
    assign vc_bad      = up.flit_wr && !is_onehot(up.vc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_ACTIVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping drain_req always wins over the IDLE entry condition.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACTIVE: begin
                if (drain_req) state_nxt = ST_DRAINING;
            end
            ST_DRAINING: begin
                if (!drain_req) begin
                    state_nxt = ST_ACTIVE;
                end else if ((open_vc == '0) && (inflight_cnt == 4'd0) && crd_empty) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!drain_req) begin
                    state_nxt = ST_ACTIVE;
                end else if (hdr_in_idle) begin
                    state_nxt = ST_DRAINING;
                end
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    assign link_state = state;

    // Credit steering.
    // While parked, credits on VCs with no open packet are held back.
    // Once back in ACTIVE, each held credit is paid out at one per cycle.
    // During payback, a fresh pipe credit on the same VC is added to the
    // held count instead of being emitted, so the net count stays unchanged.
    always_comb begin
        up.credit = '0;
        held_ovf  = 1'b0;
        for (int v = 0; v < V; v++) begin
            held_nxt[v] = held[v];
        end
        for (int v = 0; v < V; v++) begin
            if (state == ST_ACTIVE) begin
                if (held[v] != '0) begin
                    up.credit[v] = 1'b1;
                    if (!crd_out[v]) begin
                        held_nxt[v] = held[v] - HW'(1);
                    end
                end else begin
                    up.credit[v] = crd_out[v];
                end
            end else if (crd_out[v] && !open_vc[v]) begin
                held_nxt[v] = sat_inc(held[v]);
                if (held[v] == HW'(B)) begin
                    held_ovf = 1'b1;
                end
            end else begin
                up.credit[v] = crd_out[v];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < V; v++) begin
                held[v] <= '0;
            end
        end else begin
            for (int v = 0; v < V; v++) begin
                held[v] <= held_nxt[v];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err <= 1'b0;
        end else if (hdr_in_idle || vc_bad || held_ovf) begin
            proto_err <= 1'b1;
        end
    end
endmodule
